bht_predictor: RTL and testbench
================================

// Module: bht_predictor
// PURPOSE
//  Parametrised branch history table: 2^IDX_W entries of CNT_W-bit saturating counters.
//  Sits in fetch/decode. Gives a registered taken/not-taken prediction per lookup.
//  Trains from resolved branches and jumps in execute.
//  Successor to the fixed 8-row table: adds generic depth and counter width, correct saturating update, read/write bypass and optional gshare indexing.
// PARAMETERS
//  IDX_W     5      table index width; DEPTH = 2**IDX_W entries
//  CNT_W     2      counter width (>=1); MSB is the prediction
//  INIT_CNT  1      reset value of every counter (weakly not-taken for CNT_W=2)
//  GHR_W     IDX_W  global history length; used only with BHT_GSHARE_EN; GHR_W <= IDX_W
// PORTS
//  clk         in   1      clock, rising edge
//  arst_n      in   1      asynchronous active-low reset
//  en          in   1      global enable; when 0 no state changes, outputs hold
//  rd_valid    in   1      lookup request this cycle
//  rd_pc_idx   in   IDX_W  low PC bits (word address) of the fetched instruction
//  pred_valid  out  1      prediction and pred_idx valid (1 cycle after rd_valid&en)
//  prediction  out  1      1 = predict taken
//  pred_idx    out  IDX_W  table index used; pipeline carries it back as upd_idx
//  upd_valid   in   1      resolved branch/jump this cycle
//  upd_idx     in   IDX_W  index returned from pred_idx of that instruction
//  upd_taken   in   1      1 = branch was taken or jump executed
// BEHAVIOUR
//  - Reset (async, arst_n=0): all counters <= INIT_CNT; pred_valid, prediction, pred_idx <= 0.
//    GHR <= 0. Reset mid-operation discards any in-flight lookup; no update is applied.
//  - Lookup: en&rd_valid at edge N -> at N+1:
//    pred_valid=1, prediction=cnt[idx][CNT_W-1], pred_idx=idx.
//    With en=1 and rd_valid=0: pred_valid<=0; prediction and pred_idx hold.
//  - Update: en&upd_valid at edge N:
//    taken     -> cnt = (cnt==2**CNT_W-1) ? cnt : cnt+1
//    not taken -> cnt = (cnt==0) ? 0 : cnt-1
//    No wrap-around at either end.
//  - Same-cycle read and update:
//    idx==upd_idx -> prediction uses the post-update counter (write-first bypass).
//    Different index -> both proceed independently.
//  - One update per cycle. Updates to one index on back-to-back cycles all accumulate.
//  - All arithmetic is CNT_W-bit unsigned. Index arithmetic is IDX_W-bit with no carry.
// CONFIGURATION
//  BHT_GSHARE_EN defined:
//    - idx = rd_pc_idx ^ {{(IDX_W-GHR_W){1'b0}}, ghr}.
//    - ghr shifts left on each en&upd_valid, LSB <= upd_taken.
//    - The lookup in the same cycle uses the pre-shift ghr.
//  BHT_GSHARE_EN undefined:
//    - idx = rd_pc_idx. No ghr register exists.
//    - pred_idx == registered rd_pc_idx.
// STRUCTURE
//  - bht_pkg:
//    - localparam CNT_MAX
//    - functions sat_inc(cnt) and sat_dec(cnt)
//    - function cnt_next(cnt, taken)
//  - Counter array: flat reg array, reset by loop.
//  - Sub-module bht_ghr: shift register with en/shift/in and async reset.
//    Instantiated only under BHT_GSHARE_EN.
// TESTING
//  1. Reset: assert arst_n=0 mid-run, then lookup every idx.
//     -> prediction=0 for INIT_CNT=1; pred_valid=0 during reset.
//  2. Saturation: 5 updates taken on idx 3, then lookup -> cnt=3, prediction=1.
//     Then 5 not-taken -> cnt=0, prediction=0 (no wrap to 3).
//  3. Hysteresis: cnt=3; one not-taken -> lookup still 1; second not-taken -> 0.
//  4. Bypass: cnt[7]=1; same cycle rd_pc_idx=7 and upd_idx=7 taken -> next-cycle prediction=1.
//     With upd_idx=8 instead -> prediction=0.
//  5. Enable: en=0 with upd_valid=1 taken on idx 2 -> counter unchanged, outputs hold.
//  6. Gshare (macro on, GHR_W=5): updates taken,taken -> ghr=5'b00011.
//     Then lookup rd_pc_idx=5'b00100 -> pred_idx=5'b00111.
//     Same stimulus with macro off -> pred_idx=5'b00100.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared constants and saturating-counter helpers for the branch history table.
package bht_pkg;

  localparam int unsigned CNT_W_DEF = 2;

  // Largest value a w-bit unsigned counter can hold.
  function automatic int unsigned cnt_max_of(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned CNT_MAX = cnt_max_of(CNT_W_DEF);

  function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned max);
    return (cnt >= max) ? cnt : cnt + 32'd1;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned cnt);
    return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

  function automatic int unsigned cnt_next(input int unsigned cnt, input logic taken,
                                           input int unsigned max);
    return taken ? sat_inc(cnt, max) : sat_dec(cnt);
  endfunction

endpackage

// File: rtl/bht_ghr.sv
// Global history shift register: shifts in one resolved outcome per enabled shift.
module bht_ghr #(
  parameter int unsigned W = 5
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         en_i,
  input  logic         shift_i,
  input  logic         in_i,
  output logic [W-1:0] ghr_o
);

  logic [W-1:0] ghr_q;
  logic [W-1:0] ghr_d;

  // Next history: drop the oldest outcome, newest enters at the LSB.
  always_comb begin
    ghr_d = ghr_q;
    if (en_i && shift_i) begin
      ghr_d = W'({ghr_q, in_i});
    end
  end

  // History state with asynchronous clear.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign ghr_o = ghr_q;

endmodule

// File: rtl/bht_predictor.sv
// Branch history table of saturating counters with registered prediction and
// write-first bypass between a same-cycle update and lookup.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module bht_predictor
  import bht_pkg::*;
#(
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned INIT_CNT = 1,
  parameter int unsigned GHR_W    = IDX_W
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             en_i,
  input  logic             rd_valid_i,
  input  logic [IDX_W-1:0] rd_pc_idx_i,
  output logic             pred_valid_o,
  output logic             prediction_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int unsigned Depth  = 2 ** IDX_W;
  localparam int unsigned CntMax = cnt_max_of(CNT_W);
  localparam logic [CNT_W-1:0] InitCnt = CNT_W'(INIT_CNT);

  logic [CNT_W-1:0] cnt_q [Depth];

  logic             upd_fire;
  logic [CNT_W-1:0] upd_cnt;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rd_cnt;

  logic             pred_valid_q, pred_valid_d;
  logic             prediction_q, prediction_d;
  logic [IDX_W-1:0] pred_idx_q, pred_idx_d;

  assign upd_fire = en_i & upd_valid_i;

`ifdef BHT_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  bht_ghr #(
    .W (GHR_W)
  ) u_ghr (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .en_i    (en_i),
    .shift_i (upd_valid_i),
    .in_i    (upd_taken_i),
    .ghr_o   (ghr)
  );

  // Lookup hashes with the pre-shift history.
  assign rd_idx = rd_pc_idx_i ^ IDX_W'(ghr);
`else
  logic unused_ghr_w;
  assign unused_ghr_w = ^GHR_W;
  assign rd_idx       = rd_pc_idx_i;
`endif

  // Saturated value the updated entry will take; also feeds the bypass.
  always_comb begin
    upd_cnt = CNT_W'(cnt_next(32'(cnt_q[upd_idx_i]), upd_taken_i, CntMax));
  end

  // Write-first bypass so a lookup sees an update landing on the same edge.
  always_comb begin
    rd_cnt = cnt_q[rd_idx];
    if (upd_fire && (upd_idx_i == rd_idx)) begin
      rd_cnt = upd_cnt;
    end
  end

  // Counter array: cleared to InitCnt by reset, one entry written per cycle.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        cnt_q[IDX_W'(i)] <= InitCnt;
      end
    end else if (upd_fire) begin
      cnt_q[upd_idx_i] <= upd_cnt;
    end
  end

  // Next prediction outputs; prediction and index hold when no lookup fires.
  always_comb begin
    pred_valid_d = pred_valid_q;
    prediction_d = prediction_q;
    pred_idx_d   = pred_idx_q;
    if (en_i) begin
      pred_valid_d = rd_valid_i;
      if (rd_valid_i) begin
        prediction_d = rd_cnt[CNT_W-1];
        pred_idx_d   = rd_idx;
      end
    end
  end

  // Registered prediction outputs.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pred_valid_q <= 1'b0;
      prediction_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      prediction_q <= prediction_d;
      pred_idx_q   <= pred_idx_d;
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign prediction_o = prediction_q;
  assign pred_idx_o   = pred_idx_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed self-checking bench for bht_predictor (default 32 x 2-bit, INIT_CNT=1).
module tb_bht_predictor;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       en;
  logic       rd_valid;
  logic [4:0] rd_pc_idx;
  logic       pred_valid;
  logic       prediction;
  logic [4:0] pred_idx;
  logic       upd_valid;
  logic [4:0] upd_idx;
  logic       upd_taken;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bht_predictor #(
    .IDX_W    (5),
    .CNT_W    (2),
    .INIT_CNT (1),
    .GHR_W    (5)
  ) dut (
    .clk_i        (clk),
    .arst_ni      (arst_n),
    .en_i         (en),
    .rd_valid_i   (rd_valid),
    .rd_pc_idx_i  (rd_pc_idx),
    .pred_valid_o (pred_valid),
    .prediction_o (prediction),
    .pred_idx_o   (pred_idx),
    .upd_valid_i  (upd_valid),
    .upd_idx_i    (upd_idx),
    .upd_taken_i  (upd_taken)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [4:0] idx, input logic t);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = t;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic lookup(input logic [4:0] idx);
    rd_valid  = 1'b1;
    rd_pc_idx = idx;
    step();
    rd_valid  = 1'b0;
  endtask

  task automatic expect_pred(input string tag, input logic exp);
    check({tag, "_valid"}, 32'(pred_valid), 32'd1);
    check({tag, "_pred"}, 32'(prediction), 32'(exp));
  endtask

  initial begin
    arst_n    = 1'b0;
    en        = 1'b1;
    rd_valid  = 1'b0;
    rd_pc_idx = '0;
    upd_valid = 1'b0;
    upd_idx   = '0;
    upd_taken = 1'b0;
    #3;
    check("rst_pv", 32'(pred_valid), 32'd0);
    check("rst_pred", 32'(prediction), 32'd0);
    check("rst_idx", 32'(pred_idx), 32'd0);
    #9 arst_n = 1'b1;

    // Reset mid-run discards trained state and in-flight lookups.
    upd(5'd3, 1'b1);
    upd(5'd3, 1'b1);
    lookup(5'd3);
    expect_pred("pre_rst3", 1'b1);
    #2 arst_n = 1'b0;
    #1 check("mid_rst_pv", 32'(pred_valid), 32'd0);
    rd_valid  = 1'b1;
    rd_pc_idx = 5'd3;
    step();
    check("in_rst_pv", 32'(pred_valid), 32'd0);
    rd_valid = 1'b0;
    #2 arst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      lookup(5'(i));
      expect_pred("rst_all", 1'b0);
      check("rst_all_idx", 32'(pred_idx), 32'(i));
    end
    upd(5'd3, 1'b1);
    lookup(5'd3);
    expect_pred("rst_cnt1", 1'b1);

    // Saturation at both ends, no wrap.
    for (int i = 0; i < 5; i++) upd(5'd3, 1'b1);
    lookup(5'd3);
    expect_pred("sat_hi", 1'b1);
    for (int i = 0; i < 5; i++) upd(5'd3, 1'b0);
    lookup(5'd3);
    expect_pred("sat_lo", 1'b0);
    upd(5'd3, 1'b1);
    lookup(5'd3);
    expect_pred("sat_lo_nowrap", 1'b0);

    // Hysteresis from strongly taken.
    for (int i = 0; i < 3; i++) upd(5'd4, 1'b1);
    upd(5'd4, 1'b0);
    lookup(5'd4);
    expect_pred("hyst1", 1'b1);
    upd(5'd4, 1'b0);
    lookup(5'd4);
    expect_pred("hyst2", 1'b0);

    // Same-cycle bypass and independent index.
    rd_valid  = 1'b1;
    rd_pc_idx = 5'd7;
    upd_valid = 1'b1;
    upd_idx   = 5'd7;
    upd_taken = 1'b1;
    step();
    rd_valid  = 1'b0;
    upd_valid = 1'b0;
    expect_pred("byp_same", 1'b1);
    check("byp_same_idx", 32'(pred_idx), 32'd7);
    upd(5'd7, 1'b0);
    rd_valid  = 1'b1;
    rd_pc_idx = 5'd7;
    upd_valid = 1'b1;
    upd_idx   = 5'd8;
    upd_taken = 1'b1;
    step();
    rd_valid  = 1'b0;
    upd_valid = 1'b0;
    expect_pred("byp_diff", 1'b0);
    upd(5'd10, 1'b1);
    rd_valid  = 1'b1;
    rd_pc_idx = 5'd10;
    upd_valid = 1'b1;
    upd_idx   = 5'd10;
    upd_taken = 1'b0;
    step();
    rd_valid  = 1'b0;
    upd_valid = 1'b0;
    expect_pred("byp_nt", 1'b0);
    lookup(5'd8);
    expect_pred("byp_diff_upd", 1'b1);
    check("byp_diff_idx", 32'(pred_idx), 32'd8);

    // Enable low: nothing changes, outputs hold.
    en        = 1'b0;
    rd_valid  = 1'b1;
    rd_pc_idx = 5'd2;
    upd_valid = 1'b1;
    upd_idx   = 5'd2;
    upd_taken = 1'b1;
    step();
    rd_valid  = 1'b0;
    upd_valid = 1'b0;
    check("en0_pv", 32'(pred_valid), 32'd1);
    check("en0_pred", 32'(prediction), 32'd1);
    check("en0_idx", 32'(pred_idx), 32'd8);
    en = 1'b1;
    step();
    check("idle_pv", 32'(pred_valid), 32'd0);
    check("idle_pred", 32'(prediction), 32'd1);
    check("idle_idx", 32'(pred_idx), 32'd8);
    lookup(5'd2);
    expect_pred("en0_cnt", 1'b0);
    upd(5'd2, 1'b1);
    lookup(5'd2);
    expect_pred("en1_cnt", 1'b1);

    // Index formation after two taken outcomes from a clean history.
    #2 arst_n = 1'b0;
    #2 arst_n = 1'b1;
    upd(5'd20, 1'b1);
    upd(5'd20, 1'b1);
    lookup(5'b00100);
`ifdef BHT_GSHARE_EN
    check("gshare_idx", 32'(pred_idx), 32'b00111);
`else
    check("plain_idx", 32'(pred_idx), 32'b00100);
`endif
    check("idx_pv", 32'(pred_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
